rr_logging_bus_sink: RTL and testbench
======================================

Name: rr_logging_bus_sink

Overview:
- Terminal consumer of an rr_logging_bus_t. Sits directly downstream of the logging-bus enable switch.
- Each cycle with any logb_valid or loge_valid bit set becomes one fixed-width record. Records are buffered in a FIFO and drained over a valid/ready stream toward the log-writeback DMA.
- Drives the almful_hi/almful_lo backpressure hints back to the producers, and keeps sticky overflow and record-count status for CSR readout.

Parameters:
- LOGB_CHANNEL_CNT, 8, number of logb channels; must equal the bound interface's value.
- LOGB_DATA_WIDTH, 512, width of logb_data; must equal the interface's value.
- LOGE_CHANNEL_CNT, 8, number of loge channels; must equal the interface's value.
- FIFO_DEPTH, 64, record entries; power of two, >= 4.
- ALMFUL_HI_THRESH, 56, occupancy at or above which logb_almful_hi = 1.
- ALMFUL_LO_THRESH, 48, occupancy at or above which logb_almful_lo = 1; must be <= ALMFUL_HI_THRESH.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- in  rr_logging_bus_t.C  -  logging bus, consumer side. Reads logb_valid, loge_valid, logb_data; drives logb_almful_hi, logb_almful_lo.
- out_valid  output  1  record available.
- out_ready  input  1  downstream accepts the record.
- out_data  output  REC_W  record, packed {loge_valid, logb_valid, logb_data}, with logb_data in the LSBs.
- occupancy  output  $clog2(FIFO_DEPTH)+1  current FIFO entry count.
- overflow  output  1  sticky flag: a record was dropped.
- rec_cnt  output  32  records accepted since reset, wrapping.
- clr_status  input  1  clears overflow and rec_cnt; takes priority over a same-cycle increment.

Behaviour:
- REC_W = LOGE_CHANNEL_CNT + LOGB_CHANNEL_CNT + LOGB_DATA_WIDTH.
- Elaboration checks: parameter vs interface width mismatch -> $error. ALMFUL_LO_THRESH > ALMFUL_HI_THRESH -> $error.
- Reset: ptrs = 0, occupancy = 0, out_valid = 0, overflow = 0, rec_cnt = 0, almful_hi = 0, almful_lo = 0. out_data is don't-care while out_valid = 0.
- push_req = |logb_valid | |loge_valid. logb_data is captured only on push_req cycles.
- Accept: push_req and occupancy < FIFO_DEPTH. The full check uses registered occupancy, so a same-cycle pop does not make room. A push while full is dropped and sets overflow.
- An accepted push increments rec_cnt, wrapping 2^32-1 -> 0.
- Pop: out_valid and out_ready. The FIFO head is held stable while out_valid and !out_ready (AXI-stream rules; no combinational path from out_ready to out_valid).
- Latency: a record pushed at edge T is visible on out_valid/out_data after edge T+1 when the FIFO was empty (one cycle through the registered read stage). No bypass.
- Output stage is a 1-entry skid/prefetch register in front of the RAM. occupancy counts RAM entries plus the output register.
- Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH: occupancy is unchanged.
- Simultaneous push and pop at FIFO_DEPTH: the push is dropped, the pop proceeds, occupancy -> FIFO_DEPTH-1.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from occupancy, not pointer compare.
- almful_hi/almful_lo are registered from the next-state occupancy, so they update in the same cycle occupancy does. They are pure level compares with no hysteresis beyond the two thresholds.
- Backpressure contract: producers stop issuing new logb transactions while almful_hi = 1. Loge records may still arrive and are stored or dropped under the same rules.
- Reset asserted mid-stream flushes all entries; out_valid drops on the cycle after rst is sampled high.
- clr_status does not touch FIFO contents or occupancy.

Decomposition:
- rr_logging_pkg holds the REC_W computation as a function of the three counts, the typedef rr_log_rec_t (packed struct for the record fields), and the status-counter width constant (32).
- One natural sub-module: rr_sync_fifo_prefetch, a parameterised WIDTH/DEPTH synchronous FIFO with registered output, occupancy, and a full flag. The sink wraps it with record packing, threshold compare, and status logic.

Test Plan:
- Single logb_valid[0] = 1 with data 0xA5 for one cycle, out_ready = 1 -> out_valid high at T+1 with out_data = {0,8'h01,...A5}; rec_cnt = 1; occupancy returns to 0.
- loge_valid = 8'h80 only, logb_valid = 0 -> record with logb field 0 and loge field 0x80 is pushed; an all-zero-valid cycle pushes nothing.
- out_ready = 0, push 48 records -> almful_lo = 1 after the 48th accept and almful_hi = 0; push 8 more -> almful_hi = 1 at occupancy 56.
- out_ready = 0, push 70 records -> occupancy = 64, overflow = 1, rec_cnt = 64; then drain all 64 in order with payload matching sequence 0..63.
- At occupancy 64, push and pop in the same cycle -> push dropped, occupancy 63, overflow set; then clr_status -> overflow = 0, rec_cnt = 0, occupancy 63.
- rst pulsed with 10 entries queued -> next cycle out_valid = 0, occupancy = 0, almful_hi/lo = 0; a subsequent push behaves as from clean reset.

Source files
------------

// File: rtl/rr_logging_pkg.sv
// Shared definitions for the logging-bus sink: record width helper, record
// layout for the default bus geometry, and status-counter width.
package rr_logging_pkg;

    localparam int unsigned STAT_W          = 32;
    localparam int unsigned DEF_LOGB_CH_CNT = 8;
    localparam int unsigned DEF_LOGB_DW     = 512;
    localparam int unsigned DEF_LOGE_CH_CNT = 8;

    function automatic int unsigned rec_w(input int unsigned logb_ch_cnt,
                                          input int unsigned logb_dw,
                                          input int unsigned loge_ch_cnt);
        return loge_ch_cnt + logb_ch_cnt + logb_dw;
    endfunction

    // Field order matches the flat record: logb_data occupies the LSBs.
    typedef struct packed {
        logic [DEF_LOGE_CH_CNT-1:0] loge_valid;
        logic [DEF_LOGB_CH_CNT-1:0] logb_valid;
        logic [DEF_LOGB_DW-1:0]     logb_data;
    } rr_log_rec_t;

endpackage

// File: rtl/rr_logging_bus_t.sv
// Logging bus between producers and the sink; the sink returns
// almost-full hints on the same bus.
interface rr_logging_bus_t #(
    parameter int unsigned LOGB_CHANNEL_CNT = 8,
    parameter int unsigned LOGB_DATA_WIDTH  = 512,
    parameter int unsigned LOGE_CHANNEL_CNT = 8
);
    logic [LOGB_CHANNEL_CNT-1:0] logb_valid;
    logic [LOGB_DATA_WIDTH-1:0]  logb_data;
    logic [LOGE_CHANNEL_CNT-1:0] loge_valid;
    logic                        logb_almful_hi;
    logic                        logb_almful_lo;

    modport P (output logb_valid, logb_data, loge_valid,
               input  logb_almful_hi, logb_almful_lo);
    modport C (input  logb_valid, logb_data, loge_valid,
               output logb_almful_hi, logb_almful_lo);
endinterface

// File: rtl/rr_sync_fifo_prefetch.sv
// Synchronous FIFO with a registered one-entry output stage in front of the
// storage RAM; occupancy covers RAM plus output register.
module rr_sync_fifo_prefetch #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_accept,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             full
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("rr_sync_fifo_prefetch: DEPTH must be a power of two >= 4");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    ram_cnt;
    logic             vld;
    logic [WIDTH-1:0] dout;
    logic             pop;
    logic             load;

    always_comb begin
        full       = (cnt == CW'(DEPTH));
        wr_accept  = wr_en && !full;
        pop        = vld && rd_ready;
        ram_cnt    = cnt - CW'(vld);
        // Refill the output register whenever it is empty or being drained;
        // entries written this cycle are not yet counted, so there is no bypass.
        load       = (ram_cnt != '0) && (!vld || pop);
        count_next = cnt + CW'(wr_accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
        if (load) begin
            dout <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
                vld    <= 1'b1;
            end else if (pop) begin
                vld    <= 1'b0;
            end
            cnt <= count_next;
        end
    end

    assign rd_valid = vld;
    assign rd_data  = dout;
    assign count    = cnt;

endmodule

// File: rtl/rr_logging_bus_sink.sv
// Terminal consumer of the logging bus: packs each active cycle into a record,
// buffers it, streams it out, and reports backpressure and status.
module rr_logging_bus_sink
    import rr_logging_pkg::*;
#(
    parameter  int unsigned LOGB_CHANNEL_CNT = 8,
    parameter  int unsigned LOGB_DATA_WIDTH  = 512,
    parameter  int unsigned LOGE_CHANNEL_CNT = 8,
    parameter  int unsigned FIFO_DEPTH       = 64,
    parameter  int unsigned ALMFUL_HI_THRESH = 56,
    parameter  int unsigned ALMFUL_LO_THRESH = 48,
    localparam int unsigned REC_W = rec_w(LOGB_CHANNEL_CNT, LOGB_DATA_WIDTH, LOGE_CHANNEL_CNT),
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    rr_logging_bus_t.C          in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REC_W-1:0]    out_data,
    output logic [OCC_W-1:0]    occupancy,
    output logic                overflow,
    output logic [STAT_W-1:0]   rec_cnt,
    input  logic                clr_status
);

    if ($bits(in.logb_valid) != LOGB_CHANNEL_CNT) begin : g_logb_cnt_chk
        $error("rr_logging_bus_sink: LOGB_CHANNEL_CNT does not match bus");
    end
    if ($bits(in.logb_data) != LOGB_DATA_WIDTH) begin : g_logb_dw_chk
        $error("rr_logging_bus_sink: LOGB_DATA_WIDTH does not match bus");
    end
    if ($bits(in.loge_valid) != LOGE_CHANNEL_CNT) begin : g_loge_cnt_chk
        $error("rr_logging_bus_sink: LOGE_CHANNEL_CNT does not match bus");
    end
    if (ALMFUL_LO_THRESH > ALMFUL_HI_THRESH) begin : g_thresh_chk
        $error("rr_logging_bus_sink: ALMFUL_LO_THRESH exceeds ALMFUL_HI_THRESH");
    end

    logic             push_req;
    logic             accept;
    logic             full;
    logic [REC_W-1:0] rec;
    logic [OCC_W-1:0] occ_next;
    logic             almful_hi;
    logic             almful_lo;

    assign push_req = (|in.logb_valid) || (|in.loge_valid);
    assign rec      = {in.loge_valid, in.logb_valid, in.logb_data};

    rr_sync_fifo_prefetch #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (push_req),
        .wr_data    (rec),
        .wr_accept  (accept),
        .rd_ready   (out_ready),
        .rd_valid   (out_valid),
        .rd_data    (out_data),
        .count      (occupancy),
        .count_next (occ_next),
        .full       (full)
    );

    // Hints follow next-state occupancy so they change on the same edge as occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            almful_hi <= 1'b0;
            almful_lo <= 1'b0;
            overflow  <= 1'b0;
            rec_cnt   <= '0;
        end else begin
            almful_hi <= (occ_next >= OCC_W'(ALMFUL_HI_THRESH));
            almful_lo <= (occ_next >= OCC_W'(ALMFUL_LO_THRESH));
            if (clr_status) begin
                overflow <= 1'b0;
                rec_cnt  <= '0;
            end else begin
                if (push_req && full) begin
                    overflow <= 1'b1;
                end
                if (accept) begin
                    rec_cnt <= rec_cnt + STAT_W'(1);
                end
            end
        end
    end

    assign in.logb_almful_hi = almful_hi;
    assign in.logb_almful_lo = almful_lo;

endmodule

// File: tb/tb_rr_logging_bus_sink.sv
// Directed self-checking bench for rr_logging_bus_sink.
module tb_rr_logging_bus_sink;
    import rr_logging_pkg::*;

    localparam int unsigned LB    = 8;
    localparam int unsigned DW    = 512;
    localparam int unsigned LE    = 8;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned RW    = rec_w(LB, DW, LE);

    logic          clk = 1'b0;
    logic          rst;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [6:0]    occupancy;
    logic          overflow;
    logic [31:0]   rec_cnt;
    logic          clr_status;

    int n_cmp = 0;
    int n_err = 0;

    rr_logging_bus_t #(.LOGB_CHANNEL_CNT(LB), .LOGB_DATA_WIDTH(DW), .LOGE_CHANNEL_CNT(LE)) bus ();

    rr_logging_bus_sink #(
        .LOGB_CHANNEL_CNT (LB),
        .LOGB_DATA_WIDTH  (DW),
        .LOGE_CHANNEL_CNT (LE),
        .FIFO_DEPTH       (DEPTH),
        .ALMFUL_HI_THRESH (56),
        .ALMFUL_LO_THRESH (48)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .overflow   (overflow),
        .rec_cnt    (rec_cnt),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic [7:0] e, input logic [7:0] b, input logic [DW-1:0] d);
        rr_log_rec_t r;
        r.loge_valid = e;
        r.logb_valid = b;
        r.logb_data  = d;
        return r;
    endfunction

    task automatic drive(input logic [7:0] b, input logic [7:0] e, input logic [DW-1:0] d);
        bus.logb_valid = b;
        bus.loge_valid = e;
        bus.logb_data  = d;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        clr_status = 1'b0;
        drive(8'h00, 8'h00, '0);
        step;
        step;
        rst = 1'b0;
        chk("rst_valid",   RW'(out_valid), RW'(0));
        chk("rst_occ",     RW'(occupancy), RW'(0));
        chk("rst_ovf",     RW'(overflow), RW'(0));
        chk("rst_cnt",     RW'(rec_cnt), RW'(0));
        chk("rst_hi",      RW'(bus.logb_almful_hi), RW'(0));
        chk("rst_lo",      RW'(bus.logb_almful_lo), RW'(0));

        // Single logb record, consumer always ready
        out_ready = 1'b1;
        drive(8'h01, 8'h00, DW'(32'hA5));
        step;
        drive(8'h00, 8'h00, DW'(32'hDEAD));
        chk("t1_occ1",     RW'(occupancy), RW'(1));
        chk("t1_nvalid",   RW'(out_valid), RW'(0));
        step;
        chk("t1_valid",    RW'(out_valid), RW'(1));
        chk("t1_data",     out_data, mk(8'h00, 8'h01, DW'(32'hA5)));
        step;
        chk("t1_occ0",     RW'(occupancy), RW'(0));
        chk("t1_drained",  RW'(out_valid), RW'(0));
        chk("t1_cnt",      RW'(rec_cnt), RW'(1));

        // loge-only record; idle cycle pushes nothing
        out_ready = 1'b0;
        drive(8'h00, 8'h80, DW'(32'h1234));
        step;
        drive(8'h00, 8'h00, DW'(32'hFFFF));
        step;
        chk("t2_valid",    RW'(out_valid), RW'(1));
        chk("t2_data",     out_data, mk(8'h80, 8'h00, DW'(32'h1234)));
        chk("t2_cnt",      RW'(rec_cnt), RW'(2));
        step;
        chk("t2_idle_occ", RW'(occupancy), RW'(1));
        chk("t2_idle_cnt", RW'(rec_cnt), RW'(2));
        out_ready = 1'b1;
        step;
        chk("t2_occ0",     RW'(occupancy), RW'(0));
        out_ready = 1'b0;

        // Fill past full with consumer stalled
        clr_status = 1'b1;
        step;
        clr_status = 1'b0;
        chk("t3_clr_cnt",  RW'(rec_cnt), RW'(0));
        for (int i = 0; i < 70; i++) begin
            drive(8'h01, 8'h00, DW'(i));
            step;
            if (i == 46) chk("t3_lo_47",  RW'(bus.logb_almful_lo), RW'(0));
            if (i == 47) begin
                chk("t3_lo_48",  RW'(bus.logb_almful_lo), RW'(1));
                chk("t3_hi_48",  RW'(bus.logb_almful_hi), RW'(0));
                chk("t3_occ_48", RW'(occupancy), RW'(48));
            end
            if (i == 54) chk("t3_hi_55",  RW'(bus.logb_almful_hi), RW'(0));
            if (i == 55) begin
                chk("t3_hi_56",  RW'(bus.logb_almful_hi), RW'(1));
                chk("t3_occ_56", RW'(occupancy), RW'(56));
            end
            if (i == 63) chk("t3_ovf_64", RW'(overflow), RW'(0));
        end
        drive(8'h00, 8'h00, '0);
        chk("t3_occ_full", RW'(occupancy), RW'(64));
        chk("t3_ovf",      RW'(overflow), RW'(1));
        chk("t3_cnt",      RW'(rec_cnt), RW'(64));
        chk("t3_head",     out_data, mk(8'h00, 8'h01, DW'(0)));

        // Clear status, then push+pop at full
        clr_status = 1'b1;
        step;
        clr_status = 1'b0;
        chk("t4_clr_ovf",  RW'(overflow), RW'(0));
        chk("t4_clr_cnt",  RW'(rec_cnt), RW'(0));
        chk("t4_clr_occ",  RW'(occupancy), RW'(64));
        drive(8'h01, 8'h00, DW'(99));
        out_ready = 1'b1;
        step;
        drive(8'h00, 8'h00, '0);
        out_ready = 1'b0;
        chk("t4_pp_occ",   RW'(occupancy), RW'(63));
        chk("t4_pp_ovf",   RW'(overflow), RW'(1));
        chk("t4_pp_cnt",   RW'(rec_cnt), RW'(0));
        chk("t4_pp_head",  out_data, mk(8'h00, 8'h01, DW'(1)));
        clr_status = 1'b1;
        step;
        clr_status = 1'b0;
        chk("t4_clr2_ovf", RW'(overflow), RW'(0));
        chk("t4_clr2_occ", RW'(occupancy), RW'(63));
        chk("t4_hi_63",    RW'(bus.logb_almful_hi), RW'(1));
        out_ready = 1'b1;
        for (int i = 1; i < 64; i++) begin
            chk("t4_drain_v", RW'(out_valid), RW'(1));
            chk("t4_drain_d", out_data, mk(8'h00, 8'h01, DW'(i)));
            step;
        end
        chk("t4_end_occ",  RW'(occupancy), RW'(0));
        chk("t4_end_v",    RW'(out_valid), RW'(0));
        chk("t4_end_hi",   RW'(bus.logb_almful_hi), RW'(0));
        chk("t4_end_lo",   RW'(bus.logb_almful_lo), RW'(0));
        out_ready = 1'b0;

        // Mid-stream reset
        for (int i = 0; i < 10; i++) begin
            drive(8'h04, 8'h00, DW'(100 + i));
            step;
        end
        drive(8'h00, 8'h00, '0);
        chk("t5_occ10",    RW'(occupancy), RW'(10));
        chk("t5_cnt10",    RW'(rec_cnt), RW'(10));
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("t5_rst_v",    RW'(out_valid), RW'(0));
        chk("t5_rst_occ",  RW'(occupancy), RW'(0));
        chk("t5_rst_hi",   RW'(bus.logb_almful_hi), RW'(0));
        chk("t5_rst_lo",   RW'(bus.logb_almful_lo), RW'(0));
        chk("t5_rst_cnt",  RW'(rec_cnt), RW'(0));
        clr_status = 1'b1;
        drive(8'h02, 8'h00, DW'(32'h55));
        step;
        clr_status = 1'b0;
        drive(8'h00, 8'h00, '0);
        chk("t5_clr_prio", RW'(rec_cnt), RW'(0));
        chk("t5_occ1",     RW'(occupancy), RW'(1));
        step;
        chk("t5_valid",    RW'(out_valid), RW'(1));
        chk("t5_data",     out_data, mk(8'h00, 8'h02, DW'(32'h55)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
